// File: rtl/final_adder_pkg.sv
// final_adder_pkg: shared definitions for the sequential final adder.
// Holds the controller state encoding, default operand/chunk widths and
// the chunk-count derivation used by final_adder_seq.
package final_adder_pkg;

    // Controller states: wait for a row pair, add chunk by chunk, present result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } fa_state_e;

    // Default operand width of the compressor-tree rows.
    localparam int unsigned FA_DEFAULT_WIDTH = 16;

    // Default number of bits added per cycle.
    localparam int unsigned FA_DEFAULT_CHUNK = 4;

    // Number of ADD cycles needed to cover a WIDTH-bit row pair.
    function automatic int unsigned fa_nchunk(input int unsigned width,
                                              input int unsigned chunk);
        return width / chunk;
    endfunction

endpackage : final_adder_pkg

// File: rtl/final_adder_seq_chunk_adder.sv
// chunk_adder: CHUNK-bit ripple-carry adder built from one-bit full-adder
// cells. Purely combinational; the sequential final adder drives it with a
// different chunk of the latched rows on every ADD cycle.
module chunk_adder
    import final_adder_pkg::*;
#(
    parameter int unsigned CHUNK = FA_DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    // Ripple carry chain; c[0] is the incoming carry, c[CHUNK] the outgoing one.
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];

endmodule : chunk_adder

// File: rtl/final_adder_seq.sv
// final_adder_seq: sequential carry-propagate adder for the sum/carry rows
// of a compressor tree. A row pair is accepted in IDLE, added CHUNK bits
// per cycle through a single shared chunk_adder, and the WIDTH+1-bit result
// (MSB = final carry-out) is held in DONE until the consumer takes it.
// Build option: define FINAL_ADDER_APPROX_LSB_EN to replace the lowest chunk
// by a bitwise OR of the rows with no carry into the next chunk; timing and
// handshake are unchanged.
module final_adder_seq
    import final_adder_pkg::*;
#(
    parameter int unsigned WIDTH = FA_DEFAULT_WIDTH,
    parameter int unsigned CHUNK = FA_DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_row,
    input  logic [WIDTH-1:0] carry_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result
);

    localparam int unsigned NCHUNK = fa_nchunk(WIDTH, CHUNK);
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    // A row that does not split into whole chunks cannot be added correctly.
    if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("final_adder_seq: WIDTH must be a multiple of CHUNK");
    end

    fa_state_e        state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] crow_q, crow_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH:0]   result_q, result_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    int unsigned      base;
    logic [CHUNK-1:0] op_a, op_b;
    logic [CHUNK-1:0] add_s, chunk_s;
    logic             add_cout, chunk_cout;

    // Select the current chunk of both latched rows.
    always_comb begin
        base = 32'(idx_q) * CHUNK;
        op_a = sum_q[base +: CHUNK];
        op_b = crow_q[base +: CHUNK];
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_cout)
    );

    // Per-chunk result, optionally approximated for the lowest chunk.
    always_comb begin
        chunk_s    = add_s;
        chunk_cout = add_cout;
`ifdef FINAL_ADDER_APPROX_LSB_EN
        if (idx_q == '0) begin
            chunk_s    = op_a | op_b;
            chunk_cout = 1'b0;
        end
`else
`endif
    end

    // Next-state and datapath updates for the IDLE/ADD/DONE controller.
    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        crow_d      = crow_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        result_d    = result_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sum_d      = sum_row;
                    crow_d     = carry_row;
                    carry_d    = 1'b0;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_ADD;
                end
            end
            ST_ADD: begin
                result_d[base +: CHUNK] = chunk_s;
                carry_d                 = chunk_cout;
                idx_d                   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    result_d[WIDTH] = chunk_cout;
                    idx_d           = '0;
                    out_valid_d     = 1'b1;
                    state_d         = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, datapath and registered handshake outputs; reset discards any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sum_q       <= '0;
            crow_q      <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            crow_q      <= crow_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule : final_adder_seq

// File: tb/tb_final_adder_seq.sv
// tb_final_adder_seq: scoreboard bench for final_adder_seq at WIDTH=16,
// CHUNK=4. Expected values are hand-computed; the FINAL_ADDER_APPROX_LSB_EN
// build selects the approximate-LSB expectations.
module tb_final_adder_seq;

    localparam int unsigned W = 16;
    localparam int unsigned C = 4;
    localparam int unsigned LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] sum_row = '0;
    logic [W-1:0] carry_row = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W:0]   result;

    final_adder_seq #(
        .WIDTH (W),
        .CHUNK (C)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_row   (sum_row),
        .carry_row (carry_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    int unsigned cycle = 0;
    always @(posedge clk) cycle++;

    typedef struct {
        logic [W:0]  exp;
        int unsigned acc;
        string       name;
    } entry_t;

    entry_t      sb[$];
    int          checks = 0;
    int          failures = 0;
    int          busy_viol = 0;
    bit          busy = 1'b0;
    int          pushed = 0;
    int          seen = 0;
    int unsigned last_acc = 0;
    int unsigned prev_acc = 0;
    bit          prev_ov = 1'b0;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: latency on every out_valid rise, result compare on every consume.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (busy && in_ready) busy_viol++;
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=0x%0h required=no_output", result);
                end else begin
                    check({sb[0].name, "_latency"}, (W+1)'(cycle - sb[0].acc), (W+1)'(LAT));
                end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                check(sb[0].name, result, sb[0].exp);
                void'(sb.pop_front());
                busy = 1'b0;
                seen++;
            end
            prev_ov = out_valid;
        end
    end

    // Offer one row pair; push the expectation at the acceptance edge.
    task automatic send(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W:0] exp);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept_timeout in_ready=0 required=1", name);
            return;
        end
        sum_row   = a;
        carry_row = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        prev_acc = last_acc;
        last_acc = cycle;
        sb.push_back('{exp, cycle, name});
        pushed++;
        busy = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_drain_timeout pending=%0d required=0", name, sb.size());
            sb.delete();
            busy = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

`ifdef FINAL_ADDER_APPROX_LSB_EN
    localparam logic [W:0] EXP_FFFF_1    = 17'h0FFFF;
    localparam logic [W:0] EXP_00FF_1    = 17'h000FF;
    localparam logic [W:0] EXP_ABCD_1234 = 17'h0BDFD;
    localparam logic [W:0] EXP_FFFF_FFFF = 17'h1FFEF;
`else
    localparam logic [W:0] EXP_FFFF_1    = 17'h10000;
    localparam logic [W:0] EXP_00FF_1    = 17'h00100;
    localparam logic [W:0] EXP_ABCD_1234 = 17'h0BE01;
    localparam logic [W:0] EXP_FFFF_FFFF = 17'h1FFFE;
`endif

    initial begin
        logic [W:0] r0;
        int n;

        #2 rst_n = 1'b0;
        #1;
        check("reset_in_ready", {16'b0, in_ready}, 17'h1);
        check("reset_out_valid", {16'b0, out_valid}, 17'h0);
        check("reset_result", result, 17'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic vectors including carry ripple through every chunk.
        send("ffff_0001", 16'hFFFF, 16'h0001, EXP_FFFF_1);
        drain("ffff_0001");
        send("1230_4301", 16'h1230, 16'h4301, 17'h05531);
        send("ffff_ffff", 16'hFFFF, 16'hFFFF, EXP_FFFF_FFFF);
        send("zero", 16'h0000, 16'h0000, 17'h00000);
        drain("basic");

        // Back-to-back with out_ready held high.
        out_ready = 1'b1;
        send("b2b_1234_4321", 16'h1234, 16'h4321, 17'h05555);
        send("b2b_8000_8000", 16'h8000, 16'h8000, 17'h10000);
        check("b2b_accept_gap", (W+1)'(last_acc - prev_acc), (W+1)'(LAT + 2));
        drain("b2b");

        // Backpressure in DONE.
        out_ready = 1'b0;
        send("bp_abcd_1234", 16'hABCD, 16'h1234, EXP_ABCD_1234);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        r0 = result;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid_held", {16'b0, out_valid}, 17'h1);
            check("bp_in_ready_low", {16'b0, in_ready}, 17'h0);
            check("bp_result_stable", result, r0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", {16'b0, in_ready}, 17'h1);
        check("bp_release_out_valid", {16'b0, out_valid}, 17'h0);
        drain("bp");

        // Reset after the second ADD cycle discards the operation.
        send("rst_victim", 16'h5A5A, 16'h0101, 17'h05B5B);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {16'b0, out_valid}, 17'h0);
        check("midrst_in_ready", {16'b0, in_ready}, 17'h1);
        check("midrst_result", result, 17'h0);
        sb.delete();
        pushed--;
        busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send("post_rst_00ff_0001", 16'h00FF, 16'h0001, EXP_00FF_1);
        drain("post_rst");

        // Input churn and in_valid pulses during ADD must be ignored.
        send("churn_1111_2222", 16'h1111, 16'h2222, 17'h03333);
        sum_row   = 16'hFFFF;
        carry_row = 16'hFFFF;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        sum_row   = 16'h0F0F;
        carry_row = 16'hF0F0;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        sum_row   = '0;
        carry_row = '0;
        drain("churn");
        repeat (8) @(posedge clk);
        #1;

        check("in_ready_busy_violations", (W+1)'(busy_viol), 17'h0);
        check("results_vs_accepts", (W+1)'(seen), (W+1)'(pushed));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_final_adder_seq

// File: doc/final_adder_seq.md
FINAL_ADDER_SEQ -- requirements
Module: final_adder_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand width of the sum/carry rows from the compressor tree.
REQ-002 Parameter CHUNK, default 4: bits added per cycle; WIDTH SHALL be a multiple of CHUNK, otherwise elaboration SHALL fail.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  row pair on sum_row/carry_row is valid.
REQ-006 in_ready  output  1  block can accept a row pair.
REQ-007 sum_row  input  WIDTH  sum vector from the compressor tree.
REQ-008 carry_row  input  WIDTH  carry vector, already weight-aligned by the compressor tree.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  WIDTH+1  sum_row + carry_row, with the MSB as the final carry-out.

Function
REQ-012 FSM states SHALL be IDLE, ADD and DONE; NCHUNK = WIDTH/CHUNK.
REQ-013 IDLE: in_ready=1; in_valid&in_ready SHALL latch both rows, clear carry reg and chunk index, and go to ADD.
REQ-014 ADD: each cycle SHALL add chunk[idx] of both rows plus carry reg, write the CHUNK-bit sum into result[idx*CHUNK +: CHUNK], update carry reg and increment idx.
REQ-015 ADD: after chunk NCHUNK-1, result[WIDTH] SHALL take the final carry and the FSM SHALL go to DONE.
REQ-016 Latency: out_valid SHALL rise exactly NCHUNK cycles after the acceptance edge (4 cycles at default parameters).
REQ-017 DONE: out_valid=1; result SHALL be held stable until out_valid&out_ready, then the FSM SHALL return to IDLE.
REQ-018 in_ready SHALL be 0 in ADD and DONE; no new input SHALL be accepted in the cycle a result is consumed.
REQ-019 Throughput SHALL be one operation per NCHUNK+2 cycles when out_ready is held high.
REQ-020 Arithmetic SHALL be unsigned modulo 2^(WIDTH+1); overflow is impossible.
REQ-021 in_valid SHALL be ignored outside IDLE, and input rows SHALL NOT affect an operation already in progress.

Reset
REQ-022 rst_n low SHALL immediately force state=IDLE, in_ready=1, out_valid=0, result=0, carry reg=0 and idx=0, including mid-ADD and mid-DONE.
REQ-023 An operation interrupted by reset SHALL be discarded; no partial result SHALL be presented.

Configuration
REQ-024 Macro FINAL_ADDER_APPROX_LSB_EN.
  - When defined, chunk 0 SHALL be computed as the bitwise OR of the two rows, with no carry into chunk 1.
  - When undefined, chunk 0 SHALL be exact like all other chunks.
  - Latency and handshake SHALL be identical in both builds.

Structure
REQ-025 Shared package final_adder_pkg SHALL hold:
  - the FSM state encoding (IDLE/ADD/DONE);
  - default WIDTH and CHUNK constants;
  - the NCHUNK derivation.
REQ-026 One sub-module, chunk_adder (CHUNK-bit ripple of one-bit full-adder cells, inputs a, b, cin; outputs s, cout), SHALL be instantiated once and reused every ADD cycle.

Verification (WIDTH=16, CHUNK=4)
REQ-027 Exact build: sum_row=0xFFFF, carry_row=0x0001 -> result=0x10000; out_valid rises 4 cycles after acceptance.
REQ-028 APPROX build: sum_row=0xFFFF, carry_row=0x0001 -> result=0x0FFFF. Then sum_row=0x1230, carry_row=0x4301 -> result=0x05531 in both builds.
REQ-029 Back-to-back with out_ready=1:
  - 0x1234+0x4321 -> 0x05555;
  - 0x8000+0x8000 -> 0x10000;
  - second acceptance exactly 6 cycles after the first;
  - in_ready=0 throughout ADD/DONE.
REQ-030 Backpressure: hold out_ready=0 for 3 cycles in DONE -> result and out_valid stable, in_ready=0; release -> IDLE next cycle.
REQ-031 Reset mid-ADD: assert rst_n=0 after the 2nd ADD cycle -> out_valid=0 and in_ready=1 at once. After release, 0x00FF+0x0001 -> 0x00100.
REQ-032 Input churn: change sum_row/carry_row and pulse in_valid during ADD -> result equals the originally latched sum; no extra acceptance occurs.
